// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle between the interconnect and one SRAM slave port.
interface ahb_sram_slave_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [3:0]            hprot;
   logic [DATA_WIDTH-1:0] hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic                  hresp;
   logic [DATA_WIDTH-1:0] hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave: byte/halfword/word access, programmable wait
// states, write-to-read forwarding and the two-cycle ERROR response.
module ahb_sram_slave #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           MEM_DEPTH   = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           WAIT_STATES = 0
) (
   input logic             hclk,
   input logic             hresetn,
   ahb_sram_slave_if.slave bus
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned ByteBits = $clog2(NumBytes);
   localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] MemBytes = (ADDR_WIDTH + 1)'(MEM_DEPTH * NumBytes);

   typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  pend_valid_q, pend_valid_d;
   logic                  pend_write_q, pend_write_d;
   logic [IdxW-1:0]       pend_idx_q, pend_idx_d;
   logic [NumBytes-1:0]   pend_be_q, pend_be_d;
   logic                  hreadyout_q, hreadyout_d;
   logic                  hresp_q, hresp_d;
   logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   logic [ADDR_WIDTH-1:0] acc_off;
   logic [2:0]            align_mask;
   logic                  acc_legal;
   logic [IdxW-1:0]       acc_idx;
   logic [NumBytes-1:0]   acc_be;
   logic                  accept;
   logic                  commit;
   logic [IdxW-1:0]       rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   int unsigned           lane_v;
   int unsigned           size_v;
   logic                  unused_ok;

   assign unused_ok = ^{bus.hburst, bus.hprot, bus.htrans[0]};

   assign acc_off = bus.haddr - BASE_ADDR;
   // Only sample a new address phase while our own data phase is not stalling.
   assign accept  = bus.hsel & bus.hready & bus.htrans[1] & hreadyout_q;
   // A legal write is committed on the edge that ends its completing cycle.
   assign commit  = (state_q == StIdle) & pend_valid_q & pend_write_q;
   assign rd_idx  = (state_q == StWait) ? pend_idx_q : acc_idx;

   // Address-phase decode: legality, word index and byte lanes.
   always_comb begin : decode
      case (bus.hsize)
         3'd0:    align_mask = 3'b000;
         3'd1:    align_mask = 3'b001;
         3'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
      acc_legal = (bus.haddr >= BASE_ADDR) && ({1'b0, acc_off} < MemBytes) &&
                  (bus.hsize <= 3'(ByteBits)) && ((bus.haddr[2:0] & align_mask) == 3'b000);
      acc_idx = acc_off[ByteBits +: IdxW];
      lane_v  = 32'(acc_off[ByteBits-1:0]);
      size_v  = 32'd1 << bus.hsize;
      for (int unsigned b = 0; b < NumBytes; b++) begin
         acc_be[b] = (b >= lane_v) && (b < lane_v + size_v);
      end
   end

   // Read word with the bytes of a write committing on this same edge merged in.
   always_comb begin : read_merge
      rd_word = mem_q[rd_idx];
      if (commit && (pend_idx_q == rd_idx)) begin
         for (int unsigned b = 0; b < NumBytes; b++) begin
            if (pend_be_q[b]) begin
               rd_word[8*b +: 8] = bus.hwdata[8*b +: 8];
            end
         end
      end
   end

   // Next state and next registered outputs of the data-phase FSM.
   always_comb begin : fsm_next
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_valid_d = pend_valid_q;
      pend_write_d = pend_write_q;
      pend_idx_d   = pend_idx_q;
      pend_be_d    = pend_be_q;
      hreadyout_d  = 1'b1;
      hresp_d      = 1'b0;
      hrdata_d     = '0;
      unique case (state_q)
         StIdle, StErr2: begin
            state_d      = StIdle;
            pend_valid_d = 1'b0;
            if (accept) begin
               if (!acc_legal) begin
                  state_d     = StErr1;
                  hreadyout_d = 1'b0;
                  hresp_d     = 1'b1;
               end else begin
                  pend_valid_d = 1'b1;
                  pend_write_d = bus.hwrite;
                  pend_idx_d   = acc_idx;
                  pend_be_d    = acc_be;
                  if (WAIT_STATES == 0) begin
                     if (!bus.hwrite) begin
                        hrdata_d = rd_word;
                     end
                  end else begin
                     state_d     = StWait;
                     cnt_d       = 4'(WAIT_STATES - 1);
                     hreadyout_d = 1'b0;
                  end
               end
            end
         end
         StWait: begin
            hreadyout_d = 1'b0;
            if (cnt_q == 4'd0) begin
               state_d     = StIdle;
               hreadyout_d = 1'b1;
               if (!pend_write_q) begin
                  hrdata_d = rd_word;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StErr1: begin
            state_d = StErr2;
            hresp_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state, pending data-phase fields and registered bus outputs.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_write_q <= 1'b0;
         pend_idx_q   <= '0;
         pend_be_q    <= '0;
         hreadyout_q  <= 1'b1;
         hresp_q      <= 1'b0;
         hrdata_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_write_q <= pend_write_d;
         pend_idx_q   <= pend_idx_d;
         pend_be_q    <= pend_be_d;
         hreadyout_q  <= hreadyout_d;
         hresp_q      <= hresp_d;
         hrdata_q     <= hrdata_d;
      end
   end

   // Byte-lane memory write; contents are deliberately not reset.
   always_ff @(posedge hclk) begin
      if (hresetn && commit) begin
         for (int unsigned b = 0; b < NumBytes; b++) begin
            if (pend_be_q[b]) begin
               mem_q[pend_idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.hreadyout = hreadyout_q;
   assign bus.hresp     = hresp_q;
   assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance share one driven
// bus; a transaction-level timeline model predicts every cycle's outputs.
module tb_ahb_sram_slave;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned WS1   = 3;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic hclk = 1'b0;
   logic hresetn = 1'b0;
   always #5 hclk = ~hclk;

   ahb_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
   ahb_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

   ahb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE),
                    .WAIT_STATES(0)) dut0 (.hclk(hclk), .hresetn(hresetn), .bus(b0));
   ahb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE),
                    .WAIT_STATES(WS1)) dut1 (.hclk(hclk), .hresetn(hresetn), .bus(b1));

   // One expected cycle of the selected slave's data-phase timeline.
   typedef struct packed {
      logic        rdy;
      logic        resp;
      logic        rd;
      logic        wr;
      logic        commit;
      logic [5:0]  idx;
      logic [3:0]  be;
      logic [31:0] wdata;
   } exp_t;

   logic        d_sel = 1'b0;
   logic        d_hsel = 1'b0;
   logic [1:0]  d_htrans = 2'b00;
   logic        d_hwrite = 1'b0;
   logic [2:0]  d_hsize = 3'd2;
   logic [2:0]  d_hburst = 3'd0;
   logic [31:0] d_haddr = BASE;
   logic [31:0] d_wdata = '0;
   logic [31:0] junk = '0;

   exp_t        cur = '{rdy: 1'b1, default: '0};
   logic [31:0] exp_rdata = '0;
   exp_t        q[$];
   logic [31:0] mdl_mem [2][DEPTH];
   bit          chk_en = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   int stall_run = 0, last_stall = 0, resp_run = 0, last_resp_run = 0;
   logic [31:0] last_dut_rd = '0, last_exp_rd = '0;

   assign b0.hsel   = d_hsel & (d_sel == 1'b0);
   assign b1.hsel   = d_hsel & (d_sel == 1'b1);
   assign b0.hready = (d_sel == 1'b0) ? cur.rdy : 1'b1;
   assign b1.hready = (d_sel == 1'b1) ? cur.rdy : 1'b1;
   assign b0.haddr  = d_haddr;
   assign b1.haddr  = d_haddr;
   assign b0.htrans = d_htrans;
   assign b1.htrans = d_htrans;
   assign b0.hwrite = d_hwrite;
   assign b1.hwrite = d_hwrite;
   assign b0.hsize  = d_hsize;
   assign b1.hsize  = d_hsize;
   assign b0.hburst = d_hburst;
   assign b1.hburst = d_hburst;
   assign b0.hprot  = 4'b0011;
   assign b1.hprot  = 4'b0011;
   // Write data is only meaningful during a write data phase; junk elsewhere.
   assign b0.hwdata = cur.wr ? cur.wdata : junk;
   assign b1.hwdata = cur.wr ? cur.wdata : junk;

   wire        rdy_o  = d_sel ? b1.hreadyout : b0.hreadyout;
   wire        resp_o = d_sel ? b1.hresp : b0.hresp;
   wire [31:0] rd_o   = d_sel ? b1.hrdata : b0.hrdata;
   wire        o_rdy  = d_sel ? b0.hreadyout : b1.hreadyout;
   wire        o_resp = d_sel ? b0.hresp : b1.hresp;
   wire [31:0] o_rd   = d_sel ? b0.hrdata : b1.hrdata;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: commit completing write, schedule accepted transfer, advance one cycle.
   always @(posedge hclk) begin : model
      exp_t        e, nxt;
      int unsigned lo, nb, w;
      bit          legal;
      if (!hresetn) begin
         q.delete();
         chk_en    = 1'b1;
         cur       <= '{rdy: 1'b1, default: '0};
         exp_rdata <= '0;
      end else begin
         if (cur.commit) begin
            for (int b = 0; b < 4; b++) begin
               if (cur.be[b]) mdl_mem[d_sel][cur.idx][8*b +: 8] = cur.wdata[8*b +: 8];
            end
         end
         if (d_hsel && cur.rdy && d_htrans[1]) begin
            nb    = 32'd1 << d_hsize;
            legal = (d_haddr >= BASE) && ((d_haddr - BASE) < DEPTH * 4) && (d_hsize <= 3'd2) &&
                    ((d_haddr & (nb - 1)) == 0);
            e = '0;
            if (!legal) begin
               e.resp = 1'b1;
               q.push_back(e);
               e.rdy = 1'b1;
               q.push_back(e);
            end else begin
               lo      = d_haddr & 32'd3;
               w       = d_sel ? WS1 : 0;
               e.wr    = d_hwrite;
               e.wdata = d_wdata;
               e.idx   = 6'((d_haddr - BASE) >> 2);
               for (int b = 0; b < 4; b++) e.be[b] = (b >= lo) && (b < lo + nb);
               for (int i = 0; i < w; i++) q.push_back(e);
               e.rdy    = 1'b1;
               e.rd     = !d_hwrite;
               e.commit = d_hwrite;
               q.push_back(e);
            end
         end
         nxt = (q.size() > 0) ? q.pop_front() : '{rdy: 1'b1, default: '0};
         cur       <= nxt;
         exp_rdata <= nxt.rd ? mdl_mem[d_sel][nxt.idx] : 32'h0;
      end
   end

   // Compare DUT outputs against the model in the middle of every cycle.
   always @(negedge hclk) begin
      if (chk_en) begin
         check("hreadyout", {31'b0, rdy_o}, {31'b0, cur.rdy});
         check("hresp", {31'b0, resp_o}, {31'b0, cur.resp});
         check("hrdata", rd_o, exp_rdata);
         check("idle_slave", {o_rdy, o_resp, o_rd[29:0]}, {1'b1, 1'b0, 30'h0});
         if (!rdy_o) stall_run++;
         else if (stall_run != 0) begin last_stall = stall_run; stall_run = 0; end
         if (resp_o) resp_run++;
         else if (resp_run != 0) begin last_resp_run = resp_run; resp_run = 0; end
         if (cur.rd) begin last_dut_rd = rd_o; last_exp_rd = exp_rdata; end
      end
   end

   task automatic issue(input bit hs, input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd);
      int guard = 0;
      @(negedge hclk);
      while (!cur.rdy && guard < 50) begin
         guard++;
         @(negedge hclk);
      end
      if (guard >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: got stalled %0d cycles expected under 50", guard);
      end
      junk     = $urandom;
      d_hsel   = hs;
      d_htrans = tr;
      d_hwrite = wr;
      d_hsize  = sz;
      d_haddr  = ad;
      d_wdata  = wd;
   endtask

   task automatic wr(input logic [31:0] ad, input logic [31:0] wd, input logic [2:0] sz);
      issue(1'b1, 2'b10, 1'b1, sz, ad, wd);
   endtask

   task automatic rd(input logic [31:0] ad);
      issue(1'b1, 2'b10, 1'b0, 3'd2, ad, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, 2'b00, 1'b0, 3'd2, BASE, 32'h0);
   endtask

   task automatic rand_phase(input int n);
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  tr;
      int unsigned r, lane;
      for (int i = 0; i < n; i++) begin
         r    = $urandom_range(0, 19);
         sz   = 3'($urandom_range(0, 2));
         lane = $urandom_range(0, 3) & ~((32'd1 << sz) - 1);
         a    = BASE + 4 * $urandom_range(0, DEPTH - 1) + lane;
         if (r == 0) a = BASE + DEPTH * 4 + 4 * $urandom_range(0, 7);
         if (r == 1) a = BASE - 4 * $urandom_range(1, 4);
         if (r == 2) a = a | 32'd1;
         if (r == 3) sz = 3'd3;
         tr = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
         issue($urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
      end
   endtask

   initial begin
      repeat (3) @(negedge hclk);
      hresetn = 1'b1;
      for (int s = 0; s < 2; s++) begin
         d_sel = 1'(s);
         for (int i = 0; i < DEPTH; i++) wr(BASE + 4 * i, $urandom, 3'd2);
         idle(6);
      end
      d_sel = 1'b0;

      // Zero-wait forwarding and sub-word writes.
      wr(BASE + 32'h10, 32'hDEADBEEF, 3'd2);
      rd(BASE + 32'h10);
      idle(2);
      check("fwd_model", last_exp_rd, 32'hDEADBEEF);
      check("fwd_dut", last_dut_rd, 32'hDEADBEEF);
      wr(BASE + 32'h10, 32'h11223344, 3'd2);
      wr(BASE + 32'h13, {8'hA5, 24'h5A5A5A}, 3'd0);
      rd(BASE + 32'h10);
      idle(2);
      check("byte_model", last_exp_rd, 32'hA5223344);
      check("byte_dut", last_dut_rd, 32'hA5223344);
      wr(BASE + 32'h12, {16'h55AA, 16'hC3C3}, 3'd1);
      rd(BASE + 32'h10);
      idle(2);
      check("half_model", last_exp_rd, 32'h55AA3344);
      check("half_dut", last_dut_rd, 32'h55AA3344);

      // Error responses.
      wr(BASE + DEPTH * 4, 32'hBAD0BAD0, 3'd2);
      idle(3);
      check("err_oor_resp_cycles", last_resp_run, 2);
      check("err_oor_stall", last_stall, 1);
      rd(BASE + 32'h2);
      idle(3);
      check("err_misalign_resp_cycles", last_resp_run, 2);
      wr(BASE - 4, 32'h0BAD0BAD, 3'd2);
      idle(3);

      // INCR4 burst with BUSY, IDLE and deselected cycles interleaved.
      d_hburst = 3'b011;
      wr(BASE + 32'h30, 32'hA0A0A0A0, 3'd2);
      issue(1'b1, 2'b01, 1'b1, 3'd2, BASE + 32'h34, 32'hFFFFFFFF);
      issue(1'b1, 2'b11, 1'b1, 3'd2, BASE + 32'h34, 32'hA1A1A1A1);
      issue(1'b0, 2'b11, 1'b1, 3'd2, BASE + 32'h38, 32'hEEEEEEEE);
      issue(1'b1, 2'b11, 1'b1, 3'd2, BASE + 32'h38, 32'hA2A2A2A2);
      issue(1'b1, 2'b00, 1'b1, 3'd2, BASE + 32'h3C, 32'hDDDDDDDD);
      issue(1'b1, 2'b11, 1'b1, 3'd2, BASE + 32'h3C, 32'hA3A3A3A3);
      for (int i = 0; i < 4; i++) rd(BASE + 32'h30 + 4 * i);
      d_hburst = 3'b000;
      idle(2);
      check("burst_last_model", last_exp_rd, 32'hA3A3A3A3);
      rand_phase(400);
      idle(6);

      // Three-wait instance: stall length, then reset during a write's wait.
      d_sel = 1'b1;
      wr(BASE + 32'h20, 32'hCAFEF00D, 3'd2);
      rd(BASE + 32'h20);
      idle(6);
      check("ws3_stall", last_stall, 3);
      check("ws3_rd_model", last_exp_rd, 32'hCAFEF00D);
      check("ws3_rd_dut", last_dut_rd, 32'hCAFEF00D);
      wr(BASE + 32'h20, 32'h12345678, 3'd2);
      @(negedge hclk);
      hresetn  = 1'b0;
      d_hsel   = 1'b0;
      d_htrans = 2'b00;
      @(negedge hclk);
      hresetn = 1'b1;
      rd(BASE + 32'h20);
      idle(6);
      check("rst_wait_model", last_exp_rd, 32'hCAFEF00D);
      check("rst_wait_dut", last_dut_rd, 32'hCAFEF00D);
      rand_phase(300);
      idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
